// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table extractor.
// No logic; state encoding, table-width helper and default settle time.
// Imported by the sequencer and the top level.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    localparam int SETTLE_CYCLES_DEF = 2;

    // Wide enough for the largest supported settle time (15).
    localparam int CNT_W = 4;

    function automatic int tt_width(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/tt_vector_sequencer.sv
// Walks the input vector index and the per-vector settle countdown.
// Latency: SETTLE_CYCLES cycles of settle plus one sample cycle per vector.
// Backpressure: none; advances only when the FSM reports settling/sampling.
module tt_vector_sequencer
    import tt_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_sweep,
    input  logic            settling,
    input  logic            sampling,
    output logic [N_IN-1:0] nut_in,
    output logic            settle_done,
    output logic            sample_strobe,
    output logic            last_vector
);

    localparam int TT_W  = tt_width(N_IN);
    localparam int IDX_W = N_IN + 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

    // One extra index bit so the last vector is recognised before any wrap.
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            cnt <= '0;
        end else if (start_sweep) begin
            idx <= '0;
            cnt <= CNT_LOAD;
        end else if (settling && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end else if (sampling) begin
            if (last_vector) begin
                idx <= '0;
                cnt <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
                cnt <= CNT_LOAD;
            end
        end
    end

    assign nut_in        = idx[N_IN-1:0];
    assign settle_done   = settling && (cnt == '0);
    assign sample_strobe = sampling;
    assign last_vector   = (idx == IDX_LAST);

endmodule

// File: rtl/tt_extractor.sv
// Sweeps every input vector into a netlist under test and builds its truth table.
// Latency: start accept to done = TT_W*(SETTLE_CYCLES+1)+1 cycles.
// Backpressure: start is ignored while busy; results held until the next start.
module tt_extractor
    import tt_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    localparam int TT_W         = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] expected_tt,
    output logic [N_IN-1:0] nut_in,
    input  logic            nut_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    output logic            match
);

    tt_state_e       state;
    tt_state_e       state_nxt;
    logic            start_acc;
    logic            settle_done;
    logic            sample_strobe;
    logic            last_vector;
    logic [TT_W-1:0] exp_q;
    logic [TT_W-1:0] tt_next;
    logic [N_IN-1:0] bit_pos;

    assign start_acc = start && (state == IDLE || state == DONE);

    tt_vector_sequencer #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_seq (
        .clk           (clk),
        .rst           (rst),
        .start_sweep   (start_acc),
        .settling      (state == SETTLE),
        .sampling      (state == SAMPLE),
        .nut_in        (nut_in),
        .settle_done   (settle_done),
        .sample_strobe (sample_strobe),
        .last_vector   (last_vector)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vector ? DONE : SETTLE;
            DONE:    state_nxt = start_acc ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // MSB-first placement: TT_W-1-i equals the bitwise inverse of i in N_IN bits.
    assign bit_pos = ~nut_in;

    always_comb begin
        tt_next          = tt;
        tt_next[bit_pos] = nut_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt    <= '0;
            exp_q <= '0;
            match <= 1'b0;
        end else if (start_acc) begin
            tt    <= '0;
            exp_q <= expected_tt;
            match <= 1'b0;
        end else if (sample_strobe) begin
            tt <= tt_next;
            // Compare the completed table only, so match never rises mid-sweep.
            if (last_vector) match <= (tt_next == exp_q);
        end
    end

    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_tt_extractor.sv
// Directed self-checking bench for tt_extractor: default instance plus a SETTLE_CYCLES=1 instance.
module tb_tt_extractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0;
    logic [15:0] exp_a   = '0;
    logic [3:0]  nut_in_a;
    logic        nut_out_a;
    logic        busy_a, done_a, match_a;
    logic [15:0] tt_a;

    logic        start_b = 1'b0;
    logic [15:0] exp_b   = '0;
    logic [3:0]  nut_in_b;
    logic        nut_out_b;
    logic        busy_b, done_b, match_b;
    logic [15:0] tt_b;

    int          nut_sel = 0;
    logic        x_mode  = 1'b0;
    int          sweep_cyc;
    logic        sample_window;
    logic        f_a;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tt_extractor #(.N_IN(4), .SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start_a),
        .expected_tt (exp_a),
        .nut_in      (nut_in_a),
        .nut_out     (nut_out_a),
        .busy        (busy_a),
        .done        (done_a),
        .tt          (tt_a),
        .match       (match_a)
    );

    tt_extractor #(.N_IN(4), .SETTLE_CYCLES(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .start       (start_b),
        .expected_tt (exp_b),
        .nut_in      (nut_in_b),
        .nut_out     (nut_out_b),
        .busy        (busy_b),
        .done        (done_b),
        .tt          (tt_b),
        .match       (match_b)
    );

    // Bench's own notion of where the sample cycle falls (settle 2 + sample 1).
    always @(posedge clk or posedge rst) begin
        if (rst)                      sweep_cyc <= 0;
        else if (start_a && !busy_a)  sweep_cyc <= 1;
        else if (sweep_cyc != 0)      sweep_cyc <= sweep_cyc + 1;
    end

    assign sample_window = (sweep_cyc >= 1) && (((sweep_cyc - 1) % 3) == 2);

    always_comb begin
        case (nut_sel)
            0:       f_a = &nut_in_a;
            1:       f_a = |nut_in_a;
            default: f_a = nut_in_a[1] ^ nut_in_a[3];
        endcase
        nut_out_a = (x_mode && !sample_window) ? 1'bx : f_a;
    end

    assign nut_out_b = nut_in_b[0];

    task automatic run_sweep_a(input logic [15:0] exp, output int lat, output logic busy1);
        @(negedge clk);
        start_a = 1'b1;
        exp_a   = exp;
        @(negedge clk);
        start_a = 1'b0;
        busy1   = busy_a;
        lat     = 1;
        while (!done_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (nut_in_a !== 4'h0) $display("FAIL reset_nut_in got %h want 0", nut_in_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0)   $display("FAIL reset_busy got %b want 0", busy_a); else n_pass++;
        n_checks++; if (done_a !== 1'b0)   $display("FAIL reset_done got %b want 0", done_a); else n_pass++;
        n_checks++; if (tt_a !== 16'h0)    $display("FAIL reset_tt got %h want 0000", tt_a); else n_pass++;
        n_checks++; if (match_a !== 1'b0)  $display("FAIL reset_match got %b want 0", match_a); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_and;
        int   lat;
        logic b1;
        nut_sel = 0;
        run_sweep_a(16'h0001, lat, b1);
        n_checks++; if (b1 !== 1'b1)       $display("FAIL and_busy_after_accept got %b want 1", b1); else n_pass++;
        n_checks++; if (lat != 49)         $display("FAIL and_latency got %0d want 49", lat); else n_pass++;
        n_checks++; if (tt_a !== 16'h0001) $display("FAIL and_tt got %h want 0001", tt_a); else n_pass++;
        n_checks++; if (match_a !== 1'b1)  $display("FAIL and_match got %b want 1", match_a); else n_pass++;
        @(negedge clk);
        n_checks++; if (done_a !== 1'b0)   $display("FAIL and_done_one_cycle got %b want 0", done_a); else n_pass++;
        n_checks++; if (tt_a !== 16'h0001) $display("FAIL and_tt_held got %h want 0001", tt_a); else n_pass++;
    endtask

    task automatic test_or;
        int   lat;
        logic b1;
        nut_sel = 1;
        run_sweep_a(16'h7FFF, lat, b1);
        n_checks++; if (tt_a !== 16'h7FFF) $display("FAIL or_tt got %h want 7fff", tt_a); else n_pass++;
        n_checks++; if (match_a !== 1'b1)  $display("FAIL or_match got %b want 1", match_a); else n_pass++;
        run_sweep_a(16'h7FFE, lat, b1);
        n_checks++; if (lat != 49)         $display("FAIL or_rerun_latency got %0d want 49", lat); else n_pass++;
        n_checks++; if (tt_a !== 16'h7FFF) $display("FAIL or_rerun_tt got %h want 7fff", tt_a); else n_pass++;
        n_checks++; if (match_a !== 1'b0)  $display("FAIL or_mismatch_match got %b want 0", match_a); else n_pass++;
    endtask

    task automatic test_passthrough;
        logic [3:0] want;
        @(negedge clk);
        start_b = 1'b1;
        exp_b   = 16'h5555;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            want = 4'((k - 1) / 2);
            n_checks++;
            if (nut_in_b !== want || done_b !== 1'b0)
                $display("FAIL pass_walk cycle %0d got nut_in %h done %b want nut_in %h done 0", k, nut_in_b, done_b, want);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (done_b !== 1'b1)   $display("FAIL pass_done_at_33 got %b want 1", done_b); else n_pass++;
        n_checks++; if (tt_b !== 16'h5555) $display("FAIL pass_tt got %h want 5555", tt_b); else n_pass++;
        n_checks++; if (match_b !== 1'b1)  $display("FAIL pass_match got %b want 1", match_b); else n_pass++;
        n_checks++; if (nut_in_b !== 4'h0) $display("FAIL pass_nut_in_idle got %h want 0", nut_in_b); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int   lat;
        int   guard;
        logic b1;
        logic saw_done;
        nut_sel = 1;
        @(negedge clk);
        start_a = 1'b1;
        exp_a   = 16'h7FFF;
        @(negedge clk);
        start_a = 1'b0;
        guard   = 0;
        while (nut_in_a !== 4'h7 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (tt_a !== 16'h7E00) $display("FAIL rstmid_partial_tt got %h want 7e00", tt_a); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b0)   $display("FAIL rstmid_busy got %b want 0", busy_a); else n_pass++;
        n_checks++; if (tt_a !== 16'h0)    $display("FAIL rstmid_tt got %h want 0000", tt_a); else n_pass++;
        n_checks++; if (nut_in_a !== 4'h0) $display("FAIL rstmid_nut_in got %h want 0", nut_in_a); else n_pass++;
        n_checks++; if (done_a !== 1'b0)   $display("FAIL rstmid_done got %b want 0", done_a); else n_pass++;
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_a !== 1'b0) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) $display("FAIL rstmid_no_done got %b want 0", saw_done); else n_pass++;
        run_sweep_a(16'h7FFF, lat, b1);
        n_checks++; if (lat != 49)         $display("FAIL rstmid_rerun_latency got %0d want 49", lat); else n_pass++;
        n_checks++; if (tt_a !== 16'h7FFF) $display("FAIL rstmid_rerun_tt got %h want 7fff", tt_a); else n_pass++;
        n_checks++; if (match_a !== 1'b1)  $display("FAIL rstmid_rerun_match got %b want 1", match_a); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat;
        nut_sel = 0;
        @(negedge clk);
        start_a = 1'b1;
        exp_a   = 16'h0001;
        @(negedge clk);
        start_a = 1'b0;
        lat     = 1;
        while (!done_a && lat < 200) begin
            start_a = (lat == 10);
            if (lat == 10) exp_a = 16'hFFFF;
            @(negedge clk);
            lat++;
        end
        start_a = 1'b0;
        n_checks++; if (lat != 49)         $display("FAIL b2b_ignored_start_latency got %0d want 49", lat); else n_pass++;
        n_checks++; if (match_a !== 1'b1)  $display("FAIL b2b_ignored_start_match got %b want 1", match_a); else n_pass++;
        n_checks++; if (tt_a !== 16'h0001) $display("FAIL b2b_tt got %h want 0001", tt_a); else n_pass++;
        start_a = 1'b1;
        exp_a   = 16'h0001;
        @(negedge clk);
        start_a = 1'b0;
        n_checks++; if (busy_a !== 1'b1)   $display("FAIL b2b_restart_busy got %b want 1", busy_a); else n_pass++;
        n_checks++; if (tt_a !== 16'h0)    $display("FAIL b2b_restart_tt_clear got %h want 0000", tt_a); else n_pass++;
        n_checks++; if (match_a !== 1'b0)  $display("FAIL b2b_restart_match got %b want 0", match_a); else n_pass++;
        lat = 1;
        while (!done_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat != 49)         $display("FAIL b2b_second_latency got %0d want 49", lat); else n_pass++;
        n_checks++; if (tt_a !== 16'h0001) $display("FAIL b2b_second_tt got %h want 0001", tt_a); else n_pass++;
    endtask

    task automatic test_x_settle;
        int   lat;
        logic b1;
        nut_sel = 2;
        x_mode  = 1'b1;
        run_sweep_a(16'h33CC, lat, b1);
        n_checks++; if (lat != 49)               $display("FAIL xset_latency got %0d want 49", lat); else n_pass++;
        n_checks++; if ($isunknown(tt_a) !== 1'b0) $display("FAIL xset_tt_known got %h want no X", tt_a); else n_pass++;
        n_checks++; if (tt_a !== 16'h33CC)       $display("FAIL xset_tt got %h want 33cc", tt_a); else n_pass++;
        n_checks++; if (match_a !== 1'b1)        $display("FAIL xset_match got %b want 1", match_a); else n_pass++;
        x_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_and();
        test_or();
        test_passthrough();
        test_reset_mid();
        test_back_to_back();
        test_x_settle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_extractor.md
Name: tt_extractor

Overview:
- Sequential truth-table characterization engine for the small synthesized combinational gate netlists (4-input, 1-output) in the design library.
- Performs the reverse of truth-table-to-netlist synthesis: drives every input vector into a netlist under test (NUT), samples its single output, and assembles the packed truth table.
- Compares the result against an expected table and reports pass/fail.
- Used in on-chip self-check and in the regression harness for every synthesized design.

Parameters:
- N_IN, 4, number of NUT inputs (1..6).
- SETTLE_CYCLES, 2, clock cycles between driving a vector and sampling the output (1..15).
- TT_W, 2**N_IN, truth-table width (derived; not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-high.
- start  in  1  one-cycle request to begin a sweep; sampled in IDLE or DONE only.
- expected_tt  in  TT_W  golden table; captured on accepted start.
- nut_in  out  N_IN  vector driven to the NUT; nut_in[0] drives NUT input 0.
- nut_out  in  1  NUT output, combinational from nut_in.
- busy  out  1  high from the cycle after start accept through the final sample.
- done  out  1  one-cycle pulse when tt/match become valid.
- tt  out  TT_W  extracted table, held until the next accepted start.
- match  out  1  tt == captured expected_tt; valid with done, held.

Behaviour:
- Reset values: nut_in=0, busy=0, done=0, tt=0, match=0, FSM=IDLE, vector index=0, settle counter=0.
- Bit convention (MSB-first): the response to vector i is stored in tt[TT_W-1-i]. Vector 0 lands in the MSB.
- FSM states:
  - IDLE: start=1 → capture expected_tt, index=0, nut_in=0, clear tt, go to SETTLE. busy=1 from the next cycle.
  - SETTLE: counter counts SETTLE_CYCLES-1 down to 0, then go to SAMPLE. nut_in is stable throughout.
  - SAMPLE (1 cycle): write nut_out into tt[TT_W-1-index].
    - If index==TT_W-1 → go to DONE.
    - Else index+1, nut_in=index+1, counter reloaded, go to SETTLE.
  - DONE (1 cycle): done=1, match registered, busy=0, nut_in returns to 0, go to IDLE.
- Latency: start accept to done = TT_W*(SETTLE_CYCLES+1)+1 cycles. Defaults give 49.
- start while busy: ignored; no restart and no error.
- start in the same cycle done is high: accepted as a new sweep. tt clears on the next cycle.
- Index wrap: the index counter is N_IN+1 bits wide, so TT_W-1 is detected without wrap to 0. nut_in is the low N_IN bits.
- Reset mid-sweep: all state returns to reset values immediately, with no done pulse. A partial tt is discarded (zeroed).
- nut_out is sampled only in SAMPLE. X/glitches during SETTLE are ignored.
- match is computed from the complete tt only and is never asserted mid-sweep.

Decomposition:
- Shared package tt_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - localparam function tt_width(n)=2**n;
  - default SETTLE_CYCLES constant.
- One sub-module, tt_vector_sequencer:
  - contains the index and settle counters;
  - produces nut_in, sample_strobe and last_vector.
- tt_extractor holds the FSM, the tt shift/write logic, the expected-table register and the comparator.

Test Plan:
- NUT=4-input AND, expected_tt=16'h0001, start pulse → done exactly 49 cycles after accept; tt=16'h0001, match=1.
- NUT=4-input OR, expected_tt=16'h7FFF → tt=16'h7FFF, match=1. Then rerun with expected_tt=16'h7FFE → tt=16'h7FFF, match=0.
- NUT=nut_in[0] passthrough, SETTLE_CYCLES=1 → tt=16'h5555, done 33 cycles after accept. nut_in walks 0..15 monotonically, each value held 2 cycles.
- Assert rst at vector 7 mid-sweep → next cycle: busy=0, tt=0, nut_in=0, no done pulse. A new start then completes normally.
- Pulse start again at cycle 10 of a sweep → ignored, done still at cycle 49. start in the done cycle → new sweep begins, busy=1 next cycle.
- NUT output forced X during SETTLE and valid only at SAMPLE → tt is correct (no X bits) and match=1.
